dsp48e2_model: RTL and testbench

//  Behavioral model of a DSP48E2-style slice: 27x18 signed multiplier, W/X/Y/Z operand muxes,
//  48-bit ALU, optional A/B/C/D/M/P pipeline registers. Wrapped by arithmetic primitives
//  (multiply, multiply-add, accumulate) when simulating without vendor libraries.

---
 rtl/dsp48e2_model_if.sv | 32 +++
 rtl/dsp48e2_model.sv | 174 +++++++++++++++++
 tb/tb_dsp48e2_model.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dsp48e2_model_if.sv
// Operand, control and result signals of the dsp48e2_model slice.
// The master drives operands/controls; the slave (the slice) returns p/carryout.
interface dsp48e2_model_if;
  logic        cea;
  logic        ceb;
  logic        cec;
  logic        ced;
  logic        cem;
  logic        cep;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic [26:0] d;
  logic        carryin;
  logic [4:0]  inmode;
  logic [8:0]  opmode;
  logic [3:0]  alumode;
  logic [47:0] p;
  logic        carryout;

  modport master (
    output cea, ceb, cec, ced, cem, cep,
    output a, b, c, d, carryin, inmode, opmode, alumode,
    input  p, carryout
  );

  modport slave (
    input  cea, ceb, cec, ced, cem, cep,
    input  a, b, c, d, carryin, inmode, opmode, alumode,
    output p, carryout
  );
endinterface

// File: rtl/dsp48e2_model.sv
// Behavioural DSP48E2-style slice: 27x18 signed multiplier, W/X/Y/Z muxes, 48-bit ALU.
// Define DSP48E2_MODEL_PREADD_EN to enable the D-port pre-adder selected by inmode[2].
module dsp48e2_model #(
  parameter int unsigned AREG = 32'd0,
  parameter int unsigned BREG = 32'd0,
  parameter int unsigned CREG = 32'd0,
  parameter int unsigned DREG = 32'd0,
  parameter int unsigned MREG = 32'd0,
  parameter int unsigned PREG = 32'd0,
  parameter logic [47:0] RND  = 48'h0
) (
  input logic            clock,
  input logic            reset,
  dsp48e2_model_if.slave bus
);

  logic [29:0] a_q;
  logic [17:0] b_q;
  logic [47:0] c_q;
  logic [47:0] m_q;
  logic [47:0] p_q;
  logic        co_q;

  logic [29:0] a_s;
  logic [17:0] b_s;
  logic [47:0] c_s;
  logic [26:0] amult_s;
  logic [47:0] m_d;
  logic [47:0] m_s;
  logic [47:0] p_fb_s;
  logic [47:0] w_s;
  logic [47:0] x_s;
  logic [47:0] y_s;
  logic [47:0] z_s;
  logic [50:0] sel_sum_s;
  logic [50:0] alu_wide_s;
  logic [47:0] p_d;
  logic        co_d;
  logic        unused_s;

  // A/B/C operand registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q <= 30'd0;
      b_q <= 18'd0;
      c_q <= 48'd0;
    end else begin
      if (bus.cea) a_q <= bus.a;
      if (bus.ceb) b_q <= bus.b;
      if (bus.cec) c_q <= bus.c;
    end
  end

  assign a_s = (AREG != 32'd0) ? a_q : bus.a;
  assign b_s = (BREG != 32'd0) ? b_q : bus.b;
  assign c_s = (CREG != 32'd0) ? c_q : bus.c;

`ifdef DSP48E2_MODEL_PREADD_EN
  logic [26:0] d_q;
  logic [26:0] d_s;

  // D operand register feeding the pre-adder
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_q <= 27'd0;
    end else if (bus.ced) begin
      d_q <= bus.d;
    end
  end

  assign d_s      = (DREG != 32'd0) ? d_q : bus.d;
  assign amult_s  = bus.inmode[2] ? (d_s + a_s[26:0]) : a_s[26:0];
  assign unused_s = ^{bus.inmode[4:3], bus.inmode[1:0], alu_wide_s[50:49]};
`else
  assign amult_s  = a_s[26:0];
  assign unused_s = ^{bus.inmode, bus.d, bus.ced, (DREG != 32'd0), alu_wide_s[50:49]};
`endif

  // The 45-bit product always fits, so a 48-bit signed multiply is its sign extension.
  assign m_d = 48'($signed(amult_s)) * 48'($signed(b_s));

  // Multiplier output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q <= 48'd0;
    end else if (bus.cem) begin
      m_q <= m_d;
    end
  end

  assign m_s    = (MREG != 32'd0) ? m_q : m_d;
  assign p_fb_s = (PREG != 32'd0) ? p_q : 48'd0;

  // W/X/Y/Z operand selection
  always_comb begin
    w_s = 48'd0;
    x_s = 48'd0;
    y_s = 48'd0;
    z_s = 48'd0;
    case (bus.opmode[1:0])
      2'b01:   x_s = m_s;
      2'b10:   x_s = p_fb_s;
      2'b11:   x_s = {a_s, b_s};
      default: x_s = 48'd0;
    endcase
    // X and Y both selecting M still contribute the product only once
    case (bus.opmode[3:2])
      2'b01:   y_s = (bus.opmode[1:0] == 2'b01) ? 48'd0 : m_s;
      2'b10:   y_s = {48{1'b1}};
      2'b11:   y_s = c_s;
      default: y_s = 48'd0;
    endcase
    case (bus.opmode[6:4])
      3'b010:  z_s = p_fb_s;
      3'b011:  z_s = c_s;
      default: z_s = 48'd0;
    endcase
    case (bus.opmode[8:7])
      2'b01:   w_s = p_fb_s;
      2'b10:   w_s = RND;
      2'b11:   w_s = c_s;
      default: w_s = 48'd0;
    endcase
  end

  assign sel_sum_s = {3'b000, w_s} + {3'b000, x_s} + {3'b000, y_s} + {50'd0, bus.carryin};

  // ALU: arithmetic in 51 bits so bit 48 is the carry/borrow of the true result
  always_comb begin
    alu_wide_s = 51'd0;
    p_d        = 48'd0;
    co_d       = 1'b0;
    case (bus.alumode)
      4'b0011: begin
        alu_wide_s = {3'b000, z_s} - sel_sum_s;
        p_d        = alu_wide_s[47:0];
        co_d       = alu_wide_s[48];
      end
      4'b0001: begin
        alu_wide_s = sel_sum_s - {3'b000, z_s} - 51'd1;
        p_d        = alu_wide_s[47:0];
        co_d       = alu_wide_s[48];
      end
      4'b0010: begin
        alu_wide_s = {3'b000, z_s} + sel_sum_s;
        p_d        = ~alu_wide_s[47:0];
        co_d       = alu_wide_s[48];
      end
      4'b0100: p_d = x_s ^ z_s;
      4'b1100: p_d = x_s & z_s;
      4'b1110: p_d = x_s | z_s;
      default: begin
        alu_wide_s = {3'b000, z_s} + sel_sum_s;
        p_d        = alu_wide_s[47:0];
        co_d       = alu_wide_s[48];
      end
    endcase
  end

  // P output register with carry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q  <= 48'd0;
      co_q <= 1'b0;
    end else if (bus.cep) begin
      p_q  <= p_d;
      co_q <= co_d;
    end
  end

  assign bus.p        = (PREG != 32'd0) ? p_q : p_d;
  assign bus.carryout = (PREG != 32'd0) ? co_q : co_d;

endmodule

// File: tb/tb_dsp48e2_model.sv
// Self-checking bench for dsp48e2_model: combinational vector table, P accumulation,
// a fully pipelined multiply stream checked through a scoreboard, and reset corners.
module tb_dsp48e2_model;

  logic clock = 1'b0;
  logic rst0;
  logic rst1;
  logic rst2;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  dsp48e2_model_if if0 ();
  dsp48e2_model_if if1 ();
  dsp48e2_model_if if2 ();

  dsp48e2_model #(.RND(48'h0000_0000_1000)) u0 (.clock(clock), .reset(rst0), .bus(if0));
  dsp48e2_model #(.PREG(1)) u1 (.clock(clock), .reset(rst1), .bus(if1));
  dsp48e2_model #(.AREG(1), .BREG(1), .CREG(1), .MREG(1), .PREG(1))
    u2 (.clock(clock), .reset(rst2), .bus(if2));

  typedef struct {
    string       name;
    logic [29:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [26:0] d;
    logic [4:0]  inmode;
    logic [8:0]  opmode;
    logic [3:0]  alumode;
    logic        cin;
    logic [47:0] exp_p;
    logic        exp_co;
  } vec_t;

  localparam int NV = 19;
  vec_t        tbl [NV];
  logic [47:0] sb_q [$];

  task automatic check(input string name, input logic [47:0] act_p, input logic act_co,
                       input logic [47:0] exp_p, input logic exp_co);
    checks++;
    if ({act_co, act_p} !== {exp_co, exp_p}) begin
      errors++;
      $display("FAIL %s: got p=%h co=%b, want p=%h co=%b", name, act_p, act_co, exp_p, exp_co);
    end
  endtask

  function automatic logic [47:0] mulm(input logic [26:0] av, input logic [17:0] bv);
    longint sa;
    longint sbv;
    longint pr;
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    pr  = sa * sbv;
    return pr[47:0];
  endfunction

  initial begin
    logic [29:0] ra;
    logic [17:0] rb;
    logic [47:0] e;
    logic [47:0] pre_exp;

`ifdef DSP48E2_MODEL_PREADD_EN
    pre_exp = 48'd45;
`else
    pre_exp = 48'd15;
`endif

    tbl[0]  = '{"mul_neg",  30'd3, 18'h3FFFE, 48'd0, 27'd0, 5'd0, 9'h005, 4'b0000, 1'b0, 48'hFFFF_FFFF_FFFA, 1'b0};
    tbl[1]  = '{"mul_min",  30'h0400_0000, 18'h2_0000, 48'd0, 27'd0, 5'd0, 9'h005, 4'b0000, 1'b0, 48'h0800_0000_0000, 1'b0};
    tbl[2]  = '{"sub_c",    30'd3, 18'd4, 48'd100, 27'd0, 5'd0, 9'h035, 4'b0011, 1'b0, 48'd88, 1'b0};
    tbl[3]  = '{"add_c",    30'd3, 18'd4, 48'd100, 27'd0, 5'd0, 9'h035, 4'b0000, 1'b0, 48'd112, 1'b0};
    tbl[4]  = '{"ab_wrap",  30'h3FFF_FFFF, 18'h3FFFF, 48'd1, 27'd0, 5'd0, 9'h033, 4'b0000, 1'b0, 48'd0, 1'b1};
    tbl[5]  = '{"neg_z",    30'd0, 18'd10, 48'd5, 27'd0, 5'd0, 9'h033, 4'b0001, 1'b0, 48'd4, 1'b0};
    tbl[6]  = '{"not_sum",  30'd0, 18'd2, 48'd1, 27'd0, 5'd0, 9'h033, 4'b0010, 1'b0, 48'hFFFF_FFFF_FFFC, 1'b0};
    tbl[7]  = '{"xor",      30'd0, 18'h0FF00, 48'hF0F0, 27'd0, 5'd0, 9'h033, 4'b0100, 1'b0, 48'h0FF0, 1'b0};
    tbl[8]  = '{"and",      30'd0, 18'h0FF00, 48'hF0F0, 27'd0, 5'd0, 9'h033, 4'b1100, 1'b0, 48'hF000, 1'b0};
    tbl[9]  = '{"or",       30'd0, 18'h0FF00, 48'hF0F0, 27'd0, 5'd0, 9'h033, 4'b1110, 1'b0, 48'hFFF0, 1'b0};
    tbl[10] = '{"ones_cin", 30'd0, 18'd0, 48'd0, 27'd0, 5'd0, 9'h008, 4'b0000, 1'b1, 48'd0, 1'b1};
    tbl[11] = '{"w_rnd",    30'd0, 18'd0, 48'h234, 27'd0, 5'd0, 9'h130, 4'b0000, 1'b0, 48'h1234, 1'b0};
    tbl[12] = '{"w_c_z_c",  30'd0, 18'd0, 48'h10, 27'd0, 5'd0, 9'h1B0, 4'b0000, 1'b0, 48'h20, 1'b0};
    tbl[13] = '{"alu_dflt", 30'd3, 18'd4, 48'd100, 27'd0, 5'd0, 9'h035, 4'b0101, 1'b0, 48'd112, 1'b0};
    tbl[14] = '{"p_fb_0",   30'd0, 18'd7, 48'd0, 27'd0, 5'd0, 9'h0A3, 4'b0000, 1'b0, 48'd7, 1'b0};
    tbl[15] = '{"z_rsv",    30'd0, 18'd7, 48'd100, 27'd0, 5'd0, 9'h053, 4'b0000, 1'b0, 48'd7, 1'b0};
    tbl[16] = '{"y_only_m", 30'd3, 18'd4, 48'd0, 27'd0, 5'd0, 9'h004, 4'b0000, 1'b0, 48'd12, 1'b0};
    tbl[17] = '{"preadd",   30'd5, 18'd3, 48'd0, 27'd10, 5'b00100, 9'h005, 4'b0000, 1'b0, pre_exp, 1'b0};
    tbl[18] = '{"cin_add",  30'd0, 18'd1, 48'd1, 27'd0, 5'd0, 9'h033, 4'b0000, 1'b1, 48'd3, 1'b0};

    if0.cea = 1'b0; if0.ceb = 1'b0; if0.cec = 1'b0; if0.ced = 1'b0; if0.cem = 1'b0; if0.cep = 1'b0;
    if0.a = 30'd0; if0.b = 18'd0; if0.c = 48'd0; if0.d = 27'd0; if0.carryin = 1'b0;
    if0.inmode = 5'd0; if0.opmode = 9'h000; if0.alumode = 4'd0;
    if1.cea = 1'b0; if1.ceb = 1'b0; if1.cec = 1'b0; if1.ced = 1'b0; if1.cem = 1'b0; if1.cep = 1'b1;
    if1.a = 30'd5; if1.b = 18'd7; if1.c = 48'd0; if1.d = 27'd0; if1.carryin = 1'b0;
    if1.inmode = 5'd0; if1.opmode = 9'h025; if1.alumode = 4'd0;
    if2.cea = 1'b1; if2.ceb = 1'b1; if2.cec = 1'b1; if2.ced = 1'b1; if2.cem = 1'b1; if2.cep = 1'b1;
    if2.a = 30'd0; if2.b = 18'd0; if2.c = 48'd0; if2.d = 27'd0; if2.carryin = 1'b0;
    if2.inmode = 5'd0; if2.opmode = 9'h005; if2.alumode = 4'd0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("rst_p1", if1.p, if1.carryout, 48'd0, 1'b0);
    check("rst_p2", if2.p, if2.carryout, 48'd0, 1'b0);
    rst0 = 1'b0;

    // Combinational vector table on the all-REG=0 instance
    for (int i = 0; i < NV; i++) begin
      if0.a = tbl[i].a; if0.b = tbl[i].b; if0.c = tbl[i].c; if0.d = tbl[i].d;
      if0.inmode = tbl[i].inmode; if0.opmode = tbl[i].opmode;
      if0.alumode = tbl[i].alumode; if0.carryin = tbl[i].cin;
      #1;
      check(tbl[i].name, if0.p, if0.carryout, tbl[i].exp_p, tbl[i].exp_co);
    end

    // PREG=1 accumulation of M into P
    @(posedge clock);
    #1;
    check("acc_in_rst", if1.p, if1.carryout, 48'd0, 1'b0);
    rst1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      check("acc", if1.p, if1.carryout, 48'(35 * k), 1'b0);
    end
    if1.cep = 1'b0;
    @(posedge clock);
    #1;
    check("acc_hold", if1.p, if1.carryout, 48'd105, 1'b0);

    // Fully pipelined multiply stream: latency 3, expectations queued at drive time
    @(negedge clock);
    rst2 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      if (i >= 3) begin
        e = sb_q.pop_front();
        check("stream", if2.p, if2.carryout, e, 1'b0);
      end
      if (i < 12) begin
        if (i == 0) begin
          ra = 30'h0400_0000; rb = 18'h2_0000;
        end else if (i == 1) begin
          ra = 30'h03FF_FFFF; rb = 18'h1FFFF;
        end else begin
          ra = 30'($urandom); rb = 18'($urandom);
        end
        if2.a = ra;
        if2.b = rb;
        sb_q.push_back(mulm(ra[26:0], rb));
      end
    end

    // Reset in the middle of an MREG/PREG accumulation
    rst2 = 1'b1;
    #1;
    check("prst_now", if2.p, if2.carryout, 48'd0, 1'b0);
    if2.a = 30'd5; if2.b = 18'd7; if2.opmode = 9'h025;
    @(negedge clock);
    rst2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check("pacc", if2.p, if2.carryout, (k < 2) ? 48'd0 : 48'(35 * (k - 1)), 1'b0);
    end
    rst2 = 1'b1;
    #1;
    check("pacc_rst", if2.p, if2.carryout, 48'd0, 1'b0);
    @(posedge clock);
    #1;
    check("pacc_rst_hold", if2.p, if2.carryout, 48'd0, 1'b0);
    @(negedge clock);
    rst2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check("pacc_restart", if2.p, if2.carryout, (k < 2) ? 48'd0 : 48'd35, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
